// File: rtl/nod_output_arbiter.sv
// Purpose: packet-granular round-robin arbiter sharing one output link between NUM_IN NoD FIFO outputs.
// Latency: zero; the selected flit passes combinationally from in_data to dout/wr_en, with no internal buffering.
// Backpressure: full=1 withholds every in_ready (except stray-flit drains) and wr_en; a locked packet resumes intact.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_data/in_valid per-input flits (slice i at [i*DATA_WIDTH +: DATA_WIDTH]) and valids
//   in_ready         per-input accept, one-hot or zero
//   dout/wr_en/full  write port of the next stage's FIFO
//   busy/owner       link locked by a multi-flit packet, and which input holds it
//   err              sticky protocol error (stray BODY/TAIL in idle, HEAD/SINGLE inside a packet)
module nod_output_arbiter #(
   parameter int NUM_IN     = 5,
   parameter int DATA_WIDTH = 32,
   parameter int PTR_W      = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]            in_valid,
   output logic [NUM_IN-1:0]            in_ready,
   output logic [DATA_WIDTH-1:0]        dout,
   output logic                         wr_en,
   input  logic                         full,
   output logic                         busy,
   output logic [PTR_W-1:0]             owner,
   output logic                         err
);

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_t;

   localparam logic [1:0] FT_BODY   = 2'b00;
   localparam logic [1:0] FT_HEAD   = 2'b01;
   localparam logic [1:0] FT_TAIL   = 2'b10;
   localparam logic [1:0] FT_SINGLE = 2'b11;

   // (base + off) mod NUM_IN, for base < NUM_IN and 0 <= off < NUM_IN.
   function automatic logic [PTR_W-1:0] add_mod(input logic [PTR_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_IN) begin
         s = s - NUM_IN;
      end
      return s[PTR_W-1:0];
   endfunction

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic              err_q, err_d;

   logic [1:0]        ftype [NUM_IN];
   logic [NUM_IN-1:0] eligible;
   logic [NUM_IN-1:0] stray;
   logic              grant_vld;
   logic [PTR_W-1:0]  grant_idx;
   logic              stray_vld;
   logic [PTR_W-1:0]  stray_idx;
   logic [PTR_W-1:0]  sel;
   logic              ready_vld;

   // Per-input flit classification: packet starters may win arbitration,
   // anything else seen while idle is a stray to be drained.
   always_comb begin
      eligible = '0;
      stray    = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         ftype[i]    = in_data[i*DATA_WIDTH + DATA_WIDTH - 2 +: 2];
         eligible[i] = in_valid[i] & ((ftype[i] == FT_HEAD) | (ftype[i] == FT_SINGLE));
         stray[i]    = in_valid[i] & ((ftype[i] == FT_BODY) | (ftype[i] == FT_TAIL));
      end
   end

   // Round-robin scan starting at ptr; the first eligible input wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (!grant_vld && eligible[add_mod(ptr_q, k)]) begin
            grant_vld = 1'b1;
            grant_idx = add_mod(ptr_q, k);
         end
      end
   end

   // Strays are drained lowest index first (descending loop leaves the lowest).
   always_comb begin
      stray_vld = 1'b0;
      stray_idx = '0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         if (stray[i]) begin
            stray_vld = 1'b1;
            stray_idx = PTR_W'(i);
         end
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      err_d     = err_q;
      sel       = grant_idx;
      ready_vld = 1'b0;
      wr_en     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               sel = grant_idx;
               if (!full) begin
                  ready_vld = 1'b1;
                  wr_en     = 1'b1;
                  if (ftype[grant_idx] == FT_HEAD) begin
                     state_d = ST_LOCKED;
                     owner_d = grant_idx;
                  end else begin
                     ptr_d = add_mod(grant_idx, 1);
                  end
               end
            end else if (stray_vld) begin
               // Drain is accepted even when full: nothing is written downstream.
               sel       = stray_idx;
               ready_vld = 1'b1;
               err_d     = 1'b1;
            end
         end
         ST_LOCKED: begin
            sel       = owner_q;
            ready_vld = ~full;
            if (!full && in_valid[owner_q]) begin
               wr_en = 1'b1;
               case (ftype[owner_q])
                  FT_TAIL: begin
                     state_d = ST_IDLE;
                     ptr_d   = add_mod(owner_q, 1);
                  end
                  FT_HEAD, FT_SINGLE: begin
                     err_d = 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      in_ready = '0;
      if (ready_vld) begin
         in_ready[sel] = 1'b1;
      end
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (PTR_W'(i) == sel) begin
            dout = in_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         err_q   <= err_d;
      end
   end

   assign busy  = (state_q == ST_LOCKED);
   assign owner = owner_q;
   assign err   = err_q;

endmodule

// File: tb/tb_nod_output_arbiter.sv
// Bench for nod_output_arbiter: per-input flit queues act as producers, a
// packet-level model predicts every output each cycle, and directed scenarios
// pin the model with hand-computed flit orders and cycle numbers.
module tb_nod_output_arbiter;

   localparam int NUM_IN = 5;
   localparam int DW     = 32;
   localparam int PTR_W  = 3;

   localparam logic [1:0] BODY   = 2'b00;
   localparam logic [1:0] HEAD   = 2'b01;
   localparam logic [1:0] TAIL   = 2'b10;
   localparam logic [1:0] SINGLE = 2'b11;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_IN*DW-1:0]  in_data = '0;
   logic [NUM_IN-1:0]     in_valid = '0;
   logic [NUM_IN-1:0]     in_ready;
   logic [DW-1:0]         dout;
   logic                  wr_en;
   logic                  full = 1'b0;
   logic                  busy;
   logic [PTR_W-1:0]      owner;
   logic                  err;

   nod_output_arbiter #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .PTR_W(PTR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .dout     (dout),
      .wr_en    (wr_en),
      .full     (full),
      .busy     (busy),
      .owner    (owner),
      .err      (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Flit = {type, port, sequence number}.
   function automatic logic [DW-1:0] mk(input logic [1:0] t, input int p, input int s);
      return {t, 6'(p), 24'(s)};
   endfunction

   // ---------------- producers ----------------
   logic [DW-1:0] qbuf [NUM_IN][16];
   int            qh [NUM_IN];
   int            qt [NUM_IN];

   task automatic push(input int p, input logic [DW-1:0] f);
      qbuf[p][qt[p] % 16] = f;
      qt[p]++;
   endtask

   task automatic drive();
      for (int p = 0; p < NUM_IN; p++) begin
         in_valid[p] = (qt[p] > qh[p]);
         in_data[p*DW +: DW] = (qt[p] > qh[p]) ? qbuf[p][qh[p] % 16] : '0;
      end
   endtask

   logic [NUM_IN-1:0] last_ready;
   logic              last_wr;
   logic [DW-1:0]     last_dout;

   // One clock: present inputs, sample at the falling edge, pop accepted flits.
   task automatic step(input logic f);
      logic [NUM_IN-1:0] xfer;
      full = f;
      drive();
      @(negedge clk);
      xfer       = in_valid & in_ready;
      last_ready = in_ready;
      last_wr    = wr_en;
      last_dout  = dout;
      @(posedge clk);
      #1;
      for (int p = 0; p < NUM_IN; p++) begin
         if (xfer[p]) qh[p]++;
      end
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int p = 0; p < NUM_IN; p++) begin
         qh[p] = 0;
         qt[p] = 0;
      end
      full = 1'b0;
      drive();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- model and compare ----------------
   bit            m_locked = 1'b0;
   int            m_ptr    = 0;
   int            m_owner  = 0;
   bit            m_err    = 1'b0;
   int            cyc      = 0;
   logic [DW-1:0] cap_dat [256];
   int            cap_cyc [256];
   int            cap_n    = 0;

   always @(negedge clk) begin
      logic [NUM_IN-1:0] exp_ready;
      logic              exp_wr;
      logic [DW-1:0]     exp_dout;
      logic [1:0]        t;
      int                best, bestd, d, s;
      bit                n_locked, n_err;
      int                n_ptr, n_owner;

      if (rst) begin
         m_locked = 1'b0;
         m_ptr    = 0;
         m_owner  = 0;
         m_err    = 1'b0;
      end else begin
         n_locked  = m_locked;
         n_ptr     = m_ptr;
         n_owner   = m_owner;
         n_err     = m_err;
         exp_ready = '0;
         exp_wr    = 1'b0;
         exp_dout  = '0;
         if (!m_locked) begin
            // Winner = packet starter at smallest round-robin distance from ptr.
            best  = -1;
            bestd = NUM_IN;
            for (int i = 0; i < NUM_IN; i++) begin
               t = in_data[i*DW + DW - 2 +: 2];
               if (in_valid[i] && (t == HEAD || t == SINGLE)) begin
                  d = (i - m_ptr + NUM_IN) % NUM_IN;
                  if (d < bestd) begin
                     bestd = d;
                     best  = i;
                  end
               end
            end
            if (best >= 0) begin
               if (!full) begin
                  exp_ready[best] = 1'b1;
                  exp_wr          = 1'b1;
                  exp_dout        = in_data[best*DW +: DW];
                  if (exp_dout[DW-1 -: 2] == SINGLE) begin
                     n_ptr = (best + 1) % NUM_IN;
                  end else begin
                     n_locked = 1'b1;
                     n_owner  = best;
                  end
               end
            end else begin
               s = -1;
               for (int i = NUM_IN - 1; i >= 0; i--) begin
                  if (in_valid[i]) s = i;
               end
               if (s >= 0) begin
                  exp_ready[s] = 1'b1;
                  n_err        = 1'b1;
               end
            end
         end else if (!full) begin
            exp_ready[m_owner] = 1'b1;
            if (in_valid[m_owner]) begin
               exp_wr   = 1'b1;
               exp_dout = in_data[m_owner*DW +: DW];
               t        = exp_dout[DW-1 -: 2];
               if (t == TAIL) begin
                  n_locked = 1'b0;
                  n_ptr    = (m_owner + 1) % NUM_IN;
               end else if (t == HEAD || t == SINGLE) begin
                  n_err = 1'b1;
               end
            end
         end

         check("in_ready", 64'(in_ready), 64'(exp_ready));
         check("wr_en", 64'(wr_en), 64'(exp_wr));
         if (exp_wr && wr_en) check("dout", 64'(dout), 64'(exp_dout));
         check("busy", 64'(busy), 64'(m_locked));
         if (m_locked) check("owner", 64'(owner), 64'(m_owner));
         check("err", 64'(err), 64'(m_err));

         if (wr_en && cap_n < 256) begin
            cap_dat[cap_n] = dout;
            cap_cyc[cap_n] = cyc;
            cap_n++;
         end

         m_locked = n_locked;
         m_ptr    = n_ptr;
         m_owner  = n_owner;
         m_err    = n_err;
      end
      cyc++;
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int b;
      int pl[3];
      pl[0] = 0;
      pl[1] = 1;
      pl[2] = 4;

      // Reset state.
      do_reset();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_owner", 64'(owner), 64'd0);

      // Single input, port 2: HEAD, BODY, TAIL back to back.
      b = cap_n;
      push(2, mk(HEAD, 2, 0));
      push(2, mk(BODY, 2, 1));
      push(2, mk(TAIL, 2, 2));
      step(1'b0);
      check("t1_busy_after_head", 64'(busy), 64'd1);
      check("t1_owner", 64'(owner), 64'd2);
      step(1'b0);
      step(1'b0);
      check("t1_busy_after_tail", 64'(busy), 64'd0);
      check("t1_count", 64'(cap_n - b), 64'd3);
      check("t1_f0", 64'(cap_dat[b]),   64'(mk(HEAD, 2, 0)));
      check("t1_f1", 64'(cap_dat[b+1]), 64'(mk(BODY, 2, 1)));
      check("t1_f2", 64'(cap_dat[b+2]), 64'(mk(TAIL, 2, 2)));
      check("t1_contig", 64'(cap_cyc[b+2] - cap_cyc[b]), 64'd2);
      // ptr is now 3: port 3 beats port 0.
      push(0, mk(SINGLE, 0, 9));
      push(3, mk(SINGLE, 3, 9));
      step(1'b0);
      check("t1_ptr3_first", 64'(last_dout), 64'(mk(SINGLE, 3, 9)));
      step(1'b0);
      check("t1_ptr3_second", 64'(last_dout), 64'(mk(SINGLE, 0, 9)));

      // Contention: ports 0, 1, 4 stream SINGLEs.
      do_reset();
      b = cap_n;
      for (int r = 0; r < 6; r++) begin
         push(0, mk(SINGLE, 0, r));
         push(1, mk(SINGLE, 1, r));
         push(4, mk(SINGLE, 4, r));
      end
      for (int k = 0; k < 20; k++) step(1'b0);
      check("t2_count", 64'(cap_n - b), 64'd18);
      for (int k = 0; k < 18; k++) begin
         check("t2_order", 64'(cap_dat[b+k]), 64'(mk(SINGLE, pl[k % 3], k / 3)));
      end
      check("t2_contig", 64'(cap_cyc[b+17] - cap_cyc[b]), 64'd17);

      // Lock: port 1 packet while port 3 holds a HEAD.
      do_reset();
      b = cap_n;
      push(1, mk(HEAD, 1, 0));
      push(1, mk(BODY, 1, 1));
      push(1, mk(BODY, 1, 2));
      push(1, mk(TAIL, 1, 3));
      push(3, mk(HEAD, 3, 0));
      push(3, mk(TAIL, 3, 1));
      for (int k = 0; k < 4; k++) begin
         step(1'b0);
         check("t3_ready3_low", 64'(last_ready[3]), 64'd0);
      end
      step(1'b0);
      step(1'b0);
      check("t3_count", 64'(cap_n - b), 64'd6);
      check("t3_f0", 64'(cap_dat[b]),   64'(mk(HEAD, 1, 0)));
      check("t3_f3", 64'(cap_dat[b+3]), 64'(mk(TAIL, 1, 3)));
      check("t3_f4", 64'(cap_dat[b+4]), 64'(mk(HEAD, 3, 0)));
      check("t3_f5", 64'(cap_dat[b+5]), 64'(mk(TAIL, 3, 1)));
      check("t3_no_bubble", 64'(cap_cyc[b+4] - cap_cyc[b+3]), 64'd1);

      // Backpressure: full for 5 cycles mid-packet.
      do_reset();
      b = cap_n;
      push(2, mk(HEAD, 2, 0));
      for (int k = 1; k <= 4; k++) push(2, mk(BODY, 2, k));
      push(2, mk(TAIL, 2, 5));
      step(1'b0);
      step(1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1'b1);
         check("t4_full_wr", 64'(last_wr), 64'd0);
         check("t4_full_ready", 64'(last_ready), 64'd0);
      end
      for (int k = 0; k < 5; k++) step(1'b0);
      check("t4_count", 64'(cap_n - b), 64'd6);
      check("t4_f0", 64'(cap_dat[b]), 64'(mk(HEAD, 2, 0)));
      for (int k = 1; k <= 4; k++) check("t4_body", 64'(cap_dat[b+k]), 64'(mk(BODY, 2, k)));
      check("t4_f5", 64'(cap_dat[b+5]), 64'(mk(TAIL, 2, 5)));
      check("t4_gap", 64'(cap_cyc[b+2] - cap_cyc[b+1]), 64'd6);
      check("t4_busy_end", 64'(busy), 64'd0);

      // Error: stray BODY on port 0 in idle.
      do_reset();
      push(0, mk(BODY, 0, 7));
      step(1'b0);
      check("t5_drain_ready", 64'(last_ready), 64'd1);
      check("t5_drain_wr", 64'(last_wr), 64'd0);
      check("t5_err_set", 64'(err), 64'd1);
      push(1, mk(SINGLE, 1, 0));
      step(1'b0);
      check("t5_single_wr", 64'(last_wr), 64'd1);
      step(1'b0);
      step(1'b0);
      check("t5_err_sticky", 64'(err), 64'd1);
      do_reset();
      check("t5_err_cleared", 64'(err), 64'd0);

      // Reset mid-packet: ptr moved to 3 first, then lock on port 2.
      push(2, mk(SINGLE, 2, 0));
      step(1'b0);
      push(2, mk(HEAD, 2, 1));
      push(2, mk(BODY, 2, 2));
      step(1'b0);
      step(1'b0);
      check("t6_locked", 64'(busy), 64'd1);
      do_reset();
      check("t6_busy_rst", 64'(busy), 64'd0);
      check("t6_err_rst", 64'(err), 64'd0);
      push(0, mk(HEAD, 0, 0));
      push(3, mk(HEAD, 3, 0));
      step(1'b0);
      check("t6_first_wr", 64'(last_wr), 64'd1);
      check("t6_first_dout", 64'(last_dout), 64'(mk(HEAD, 0, 0)));
      check("t6_owner", 64'(owner), 64'd0);
      push(0, mk(TAIL, 0, 1));
      step(1'b0);
      step(1'b0);
      check("t6_port3_head", 64'(last_dout), 64'(mk(HEAD, 3, 0)));
      push(3, mk(TAIL, 3, 1));
      step(1'b0);
      step(1'b0);
      check("t6_err_final", 64'(err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nod_output_arbiter.md
Name: nod_output_arbiter

Overview:
- Downstream consumer of several NoD FIFO wrapper outputs (valid/ready/dout) that share one output link.
- Arbitrates round-robin at packet granularity and locks the link to one input from head flit to tail flit.
- Writes flits into the next stage's FIFO write port (din/wr_en/full).
- Sits between the per-input FIFOs and the next router's input FIFO.

Parameters:
- NUM_IN, 5, number of arbitrated inputs (2..8).
- DATA_WIDTH, 32, flit width. The flit type is bits [DATA_WIDTH-1:DATA_WIDTH-2]: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 SINGLE (head and tail in one flit).
- PTR_W, 3, index width; must satisfy 2^PTR_W >= NUM_IN.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*DATA_WIDTH  input flits; input i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_IN  per-input flit valid.
- in_ready  out  NUM_IN  per-input accept; at most one bit high in any cycle.
- dout  out  DATA_WIDTH  flit to downstream FIFO din.
- wr_en  out  1  downstream FIFO write strobe.
- full  in  1  downstream FIFO full.
- busy  out  1  high while a multi-flit packet holds the link.
- owner  out  PTR_W  index of the input holding the link; valid only when busy=1.
- err  out  1  sticky protocol error flag.

Behaviour:
- Transfer on input i: a cycle with in_valid[i] & in_ready[i].
- Output path is combinational: wr_en = (transfer of a forwarded flit); dout = the selected in_data slice. Zero latency, no internal buffering.
- wr_en is never high while full=1.
- dout is the selected input's data when wr_en=1 and is don't-care otherwise.

State machine, IDLE / LOCKED:
- IDLE, selection:
  - Eligible inputs: in_valid[i]=1 and type HEAD or SINGLE.
  - Grant goes to the first eligible input scanning ptr, ptr+1, ... (mod NUM_IN).
  - If full=0: in_ready[grant]=1 and the flit is forwarded.
- IDLE, outcome of a forwarded flit:
  - SINGLE: stay IDLE; ptr <= grant+1 mod NUM_IN.
  - HEAD: go to LOCKED; owner <= grant.
- IDLE, full=1: no ready, no grant, ptr unchanged.
- IDLE, stray flits:
  - If no eligible input exists but some in_valid[i] carries BODY or TAIL, the lowest such index is drained.
  - Drain means in_ready[i]=1, wr_en=0, err <= 1. This runs regardless of full.
- LOCKED:
  - in_ready[owner] = ~full; all other in_ready are 0.
  - Transfers from owner are forwarded regardless of type.
  - TAIL transferred: go to IDLE; ptr <= owner+1 mod NUM_IN.
  - HEAD or SINGLE transferred while LOCKED: forwarded, err <= 1, stay LOCKED.
- busy = (state==LOCKED). owner holds its value while LOCKED.
- err clears only on rst.
- Reset values: state IDLE, ptr 0, owner 0, busy 0, err 0, wr_en 0, in_ready all 0.
- A reset asserted mid-packet abandons the packet with no flush. The next flit is re-arbitrated from IDLE.
- Valid withdrawal is the producer's concern. The arbiter re-evaluates every cycle, and in IDLE a grant is not held across cycles without a transfer.
- Throughput: 1 flit/cycle sustained. Switching to a new packet costs no bubble: a TAIL in cycle n allows a HEAD from another input in cycle n+1.

Test Plan:
- Single input: port 2 sends HEAD, BODY, TAIL on consecutive cycles with full=0 -> wr_en=1 for 3 cycles, dout matches each flit, busy=1 after HEAD and 0 after TAIL, owner=2, next ptr=3.
- Contention: ports 0, 1 and 4 each present a SINGLE continuously from reset -> grant order 0, 1, 4, 0, 1, ... with one flit per cycle and never two in_ready bits high.
- Lock: port 1 sends a 4-flit packet while port 3 holds a HEAD valid -> all 4 port-1 flits are forwarded contiguously, port 3's HEAD goes out in the cycle after the TAIL, and in_ready[3]=0 throughout.
- Backpressure: full=1 for 5 cycles mid-packet -> wr_en=0 and in_ready=0 throughout; on full=0 the packet resumes with no flit lost or duplicated, checked against a scoreboard.
- Error: port 0 presents a BODY in IDLE -> it is drained (in_ready[0]=1, wr_en=0), err=1 from the next cycle and stays 1 until rst.
- Reset mid-packet: rst asserted while LOCKED on port 2 -> next cycle busy=0, err=0, ptr=0, and a HEAD on port 0 is forwarded in the first cycle after rst deasserts.
